// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared widths, state encoding and state type for the memory arbiter
package arb_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 2;

    localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
    localparam logic [1:0] ST_IF_BUSY_ENC  = 2'd1;
    localparam logic [1:0] ST_MEM_BUSY_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = ST_IDLE_ENC,
        ST_IF_BUSY  = ST_IF_BUSY_ENC,
        ST_MEM_BUSY = ST_MEM_BUSY_ENC
    } arb_state_t;

endpackage

// File: rtl/mem_arb_starve.sv
// rtl/mem_arb_starve.sv - starvation counter limiting consecutive MEM grants while IF waits
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high reset, clears the count
//   grant_if   IF is granted at this edge
//   grant_mem  MEM is granted at this edge
//   if_req     raw fetch request level at grant time
//   at_max     count has reached STARVE_MAX (IF must win the next contested grant)
module mem_arb_starve #(
    parameter int STARVE_MAX = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic grant_if,
    input  logic grant_mem,
    input  logic if_req,
    output logic at_max
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (grant_if) begin
            cnt <= '0;
        end else if (grant_mem) begin
            // Only MEM grants that actually kept IF waiting count toward starvation.
            if (!if_req) begin
                cnt <= '0;
            end else if (cnt != MAX_V) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch / load-store) arbiter onto a single-ported RAM
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   if_arb_req/addr              fetch read request (held until ack) and address
//   id_arb_flush                 abandon the fetch currently being served
//   arb_if_data/ack/stall        registered fetch data, 1-cycle ack, stall
//   mem_arb_req/we/addr/wdata    load/store request (held until ack)
//   arb_mem_data/ack/stall       registered load data, 1-cycle ack, stall
//   arb_ram_en/we/addr/wdata     registered RAM command, stable while busy
//   ram_arb_rdata/ready          RAM read data and completion strobe
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_arb_req,
    input  logic [ADDR_W-1:0] if_arb_addr,
    input  logic              id_arb_flush,
    output logic [DATA_W-1:0] arb_if_data,
    output logic              arb_if_ack,
    output logic              arb_if_stall,
    input  logic              mem_arb_req,
    input  logic              mem_arb_we,
    input  logic [ADDR_W-1:0] mem_arb_addr,
    input  logic [DATA_W-1:0] mem_arb_wdata,
    output logic [DATA_W-1:0] arb_mem_data,
    output logic              arb_mem_ack,
    output logic              arb_mem_stall,
    output logic              arb_ram_en,
    output logic              arb_ram_we,
    output logic [ADDR_W-1:0] arb_ram_addr,
    output logic [DATA_W-1:0] arb_ram_wdata,
    input  logic [DATA_W-1:0] ram_arb_rdata,
    input  logic              ram_arb_ready
);

    arb_state_t state;
    arb_state_t state_n;

    logic if_live;
    logic mem_live;
    logic starve_max;
    logic grant_if;
    logic grant_mem;
    logic done;
    logic drop;

    // A requester whose ack is showing is still holding req from the finished
    // access; it must not be granted again off that stale level.
    assign if_live  = if_arb_req  & ~arb_if_ack;
    assign mem_live = mem_arb_req & ~arb_mem_ack;

    // Priority is decided on the raw request levels: a MEM requester sitting in
    // its ack cycle still blocks a non-starved IF, so continuous MEM traffic is
    // throttled only by the starvation counter, not by the ack gap.
    assign grant_if  = (state == ST_IDLE) & if_live & (~mem_arb_req | starve_max);
    assign grant_mem = (state == ST_IDLE) & mem_live & ~grant_if;

    // ready is meaningful only while an access is outstanding.
    assign done = ram_arb_ready & (state != ST_IDLE);

    assign arb_if_stall  = if_arb_req  & ~arb_if_ack;
    assign arb_mem_stall = mem_arb_req & ~arb_mem_ack;

    mem_arb_starve #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clock    (clock),
        .reset    (reset),
        .grant_if (grant_if),
        .grant_mem(grant_mem),
        .if_req   (if_arb_req),
        .at_max   (starve_max)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (grant_mem) begin
                    state_n = ST_MEM_BUSY;
                end else if (grant_if) begin
                    state_n = ST_IF_BUSY;
                end
            end
            ST_IF_BUSY, ST_MEM_BUSY: begin
                if (ram_arb_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // RAM command, return data, acks and the flush drop flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            arb_ram_en    <= 1'b0;
            arb_ram_we    <= 1'b0;
            arb_ram_addr  <= '0;
            arb_ram_wdata <= '0;
            arb_if_data   <= '0;
            arb_mem_data  <= '0;
            arb_if_ack    <= 1'b0;
            arb_mem_ack   <= 1'b0;
            drop          <= 1'b0;
        end else begin
            arb_if_ack  <= 1'b0;
            arb_mem_ack <= 1'b0;

            if (grant_mem) begin
                arb_ram_en    <= 1'b1;
                arb_ram_we    <= mem_arb_we;
                arb_ram_addr  <= mem_arb_addr;
                arb_ram_wdata <= mem_arb_wdata;
            end else if (grant_if) begin
                arb_ram_en   <= 1'b1;
                arb_ram_we   <= 1'b0;
                arb_ram_addr <= if_arb_addr;
            end

            if (done) begin
                arb_ram_en <= 1'b0;
                arb_ram_we <= 1'b0;
                if (state == ST_MEM_BUSY) begin
                    arb_mem_ack <= 1'b1;
                    if (!arb_ram_we) begin
                        arb_mem_data <= ram_arb_rdata;
                    end
                end else if (!(drop | id_arb_flush)) begin
                    // A flush seen on the completing edge itself also discards the word.
                    arb_if_ack  <= 1'b1;
                    arb_if_data <= ram_arb_rdata;
                end
            end

            if (grant_if && id_arb_flush) begin
                drop <= 1'b1;
            end else if (state == ST_IF_BUSY) begin
                if (ram_arb_ready) begin
                    drop <= 1'b0;
                end else if (id_arb_flush) begin
                    drop <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          if_arb_req;
    logic [AW-1:0] if_arb_addr;
    logic          id_arb_flush;
    logic [DW-1:0] arb_if_data;
    logic          arb_if_ack;
    logic          arb_if_stall;
    logic          mem_arb_req;
    logic          mem_arb_we;
    logic [AW-1:0] mem_arb_addr;
    logic [DW-1:0] mem_arb_wdata;
    logic [DW-1:0] arb_mem_data;
    logic          arb_mem_ack;
    logic          arb_mem_stall;
    logic          arb_ram_en;
    logic          arb_ram_we;
    logic [AW-1:0] arb_ram_addr;
    logic [DW-1:0] arb_ram_wdata;
    logic [DW-1:0] ram_arb_rdata;
    logic          ram_arb_ready;

    int total = 0;
    int bad   = 0;
    int starve_m;
    logic [DW-1:0] exp_if_data;
    logic [DW-1:0] exp_mem_data;
    bit starve_order [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    always #5 clock = ~clock;

    mem_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .STARVE_MAX(SMAX)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .if_arb_req   (if_arb_req),
        .if_arb_addr  (if_arb_addr),
        .id_arb_flush (id_arb_flush),
        .arb_if_data  (arb_if_data),
        .arb_if_ack   (arb_if_ack),
        .arb_if_stall (arb_if_stall),
        .mem_arb_req  (mem_arb_req),
        .mem_arb_we   (mem_arb_we),
        .mem_arb_addr (mem_arb_addr),
        .mem_arb_wdata(mem_arb_wdata),
        .arb_mem_data (arb_mem_data),
        .arb_mem_ack  (arb_mem_ack),
        .arb_mem_stall(arb_mem_stall),
        .arb_ram_en   (arb_ram_en),
        .arb_ram_we   (arb_ram_we),
        .arb_ram_addr (arb_ram_addr),
        .arb_ram_wdata(arb_ram_wdata),
        .ram_arb_rdata(ram_arb_rdata),
        .ram_arb_ready(ram_arb_ready)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serve one granted access: entered just after the grant edge, left in the ack cycle.
    task automatic serve(input bit is_mem, input logic [AW-1:0] a, input bit we,
                         input logic [DW-1:0] wd, input int nw, input logic [DW-1:0] rd,
                         input int fl, input bit pre_drop, input string tag);
        bit dropped;
        bit exp_iack;
        dropped = pre_drop && !is_mem;
        for (int i = 0; i <= nw; i++) begin
            chk({tag, "_ram_en"}, arb_ram_en, 1);
            chk({tag, "_ram_addr"}, arb_ram_addr, a);
            chk({tag, "_ram_we"}, arb_ram_we, we);
            if (we) chk({tag, "_ram_wdata"}, arb_ram_wdata, wd);
            chk({tag, "_busy_if_ack"}, arb_if_ack, 0);
            chk({tag, "_busy_mem_ack"}, arb_mem_ack, 0);
            chk({tag, "_busy_if_stall"}, arb_if_stall, if_arb_req);
            chk({tag, "_busy_mem_stall"}, arb_mem_stall, mem_arb_req);
            ram_arb_ready = (i == nw);
            ram_arb_rdata = (i == nw) ? rd : DW'($urandom);
            id_arb_flush  = (i == fl);
            if (i == fl && !is_mem) dropped = 1'b1;
            tick();
        end
        ram_arb_ready = 1'b0;
        id_arb_flush  = 1'b0;
        ram_arb_rdata = DW'($urandom);
        exp_iack = !is_mem && !dropped;
        if (is_mem && !we) exp_mem_data = rd;
        if (exp_iack) exp_if_data = rd;
        chk({tag, "_done_en"}, arb_ram_en, 0);
        chk({tag, "_if_ack"}, arb_if_ack, exp_iack);
        chk({tag, "_mem_ack"}, arb_mem_ack, is_mem);
        chk({tag, "_if_data"}, arb_if_data, exp_if_data);
        chk({tag, "_mem_data"}, arb_mem_data, exp_mem_data);
        chk({tag, "_ack_if_stall"}, arb_if_stall, if_arb_req & ~exp_iack);
        chk({tag, "_ack_mem_stall"}, arb_mem_stall, mem_arb_req & ~is_mem);
    endtask

    // Raise requests together and serve them in the order the arbitration rules predict.
    task automatic round(input bit want_if, input logic [AW-1:0] ia, input int iw,
                         input logic [DW-1:0] ir, input int ifl,
                         input bit want_mem, input bit mwe, input logic [AW-1:0] ma,
                         input logic [DW-1:0] md, input int mw, input logic [DW-1:0] mr,
                         input int mfl, input bit pre_flush, input string tag);
        bit if_pend;
        bit mem_pend;
        bit first;
        bit win_mem;
        if_pend  = want_if;
        mem_pend = want_mem;
        first    = 1'b1;
        if_arb_req    = want_if;
        if_arb_addr   = ia;
        mem_arb_req   = want_mem;
        mem_arb_we    = mwe;
        mem_arb_addr  = ma;
        mem_arb_wdata = md;
        id_arb_flush  = pre_flush;
        #1;
        chk({tag, "_req_if_stall"}, arb_if_stall, want_if);
        chk({tag, "_req_mem_stall"}, arb_mem_stall, want_mem);
        while (if_pend || mem_pend) begin
            win_mem = mem_pend && !(if_pend && starve_m == SMAX);
            if (win_mem) starve_m = if_pend ? ((starve_m < SMAX) ? starve_m + 1 : SMAX) : 0;
            else starve_m = 0;
            tick();
            id_arb_flush = 1'b0;
            if (win_mem) begin
                serve(1'b1, ma, mwe, md, mw, mr, mfl, 1'b0, tag);
                mem_arb_req = 1'b0;
                mem_pend    = 1'b0;
            end else begin
                serve(1'b0, ia, 1'b0, '0, iw, ir, ifl, first && pre_flush, tag);
                if_arb_req = 1'b0;
                if_pend    = 1'b0;
            end
            first = 1'b0;
        end
        tick();
        chk({tag, "_idle_en"}, arb_ram_en, 0);
        chk({tag, "_idle_if_ack"}, arb_if_ack, 0);
        chk({tag, "_idle_mem_ack"}, arb_mem_ack, 0);
    endtask

    initial begin
        reset         = 1'b1;
        if_arb_req    = 1'b0;
        if_arb_addr   = '0;
        id_arb_flush  = 1'b0;
        mem_arb_req   = 1'b0;
        mem_arb_we    = 1'b0;
        mem_arb_addr  = '0;
        mem_arb_wdata = '0;
        ram_arb_rdata = '0;
        ram_arb_ready = 1'b0;
        exp_if_data   = '0;
        exp_mem_data  = '0;
        starve_m      = 0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_ram_en", arb_ram_en, 0);
        chk("rst_ram_we", arb_ram_we, 0);
        chk("rst_ram_addr", arb_ram_addr, 0);
        chk("rst_ram_wdata", arb_ram_wdata, 0);
        chk("rst_if_data", arb_if_data, 0);
        chk("rst_mem_data", arb_mem_data, 0);
        chk("rst_if_ack", arb_if_ack, 0);
        chk("rst_mem_ack", arb_mem_ack, 0);

        // Single load: request, grant edge, ready on first busy cycle, ack.
        round(1'b0, '0, 0, '0, -1,
              1'b1, 1'b0, 32'h40, '0, 0, 32'h1234, -1, 1'b0, "load");

        // Simultaneous: store wins, then fetch.
        round(1'b1, 32'h0, 0, 32'h5555, -1,
              1'b1, 1'b1, 32'h80, 32'hAA, 0, 32'h7777, -1, 1'b0, "simul");

        // Starvation: IF held, MEM held continuously.
        if_arb_req    = 1'b1;
        if_arb_addr   = 32'h100;
        mem_arb_req   = 1'b1;
        mem_arb_we    = 1'b1;
        mem_arb_addr  = 32'h200;
        mem_arb_wdata = 32'h77;
        for (int g = 0; g < 4; g++) begin
            int n;
            n = 0;
            tick();
            while (!arb_ram_en && n < 8) begin
                tick();
                n++;
            end
            chk("starve_grant_seen", arb_ram_en, 1);
            chk("starve_owner_is_mem", arb_ram_addr == 32'h200, starve_order[g]);
            ram_arb_ready = 1'b1;
            ram_arb_rdata = 32'h3000 + g;
            tick();
            ram_arb_ready = 1'b0;
            if (!starve_order[g]) exp_if_data = 32'h3000 + g;
        end
        if_arb_req  = 1'b0;
        mem_arb_req = 1'b0;
        starve_m    = 1;
        tick();
        chk("starve_if_data", arb_if_data, exp_if_data);
        chk("starve_mem_data", arb_mem_data, exp_mem_data);
        chk("starve_idle_en", arb_ram_en, 0);

        // Flush during IF_BUSY, and flush on the grant cycle.
        round(1'b1, 32'h300, 1, 32'hDEAD, 0,
              1'b0, 1'b0, '0, '0, 0, '0, -1, 1'b0, "flush_busy");
        round(1'b1, 32'h304, 0, 32'hBEEF, -1,
              1'b0, 1'b0, '0, '0, 0, '0, -1, 1'b1, "flush_grant");

        // Wait states: three not-ready cycles.
        round(1'b0, '0, 0, '0, -1,
              1'b1, 1'b0, 32'h500, '0, 3, 32'hCAFE, -1, 1'b0, "wait3");

        // Randomized traffic.
        for (int r = 0; r < 60; r++) begin
            bit wi;
            bit wm;
            int iw;
            int mw;
            int ifl;
            int mfl;
            wi = 1'b0;
            wm = 1'b0;
            while (!(wi || wm)) begin
                wi = 1'($urandom_range(0, 1));
                wm = 1'($urandom_range(0, 1));
            end
            iw  = $urandom_range(0, 3);
            mw  = $urandom_range(0, 3);
            ifl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, iw) : -1;
            mfl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, mw) : -1;
            round(wi, AW'($urandom), iw, DW'($urandom), ifl,
                  wm, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), mw,
                  DW'($urandom), mfl, ($urandom_range(0, 4) == 0), "rnd");
        end

        // Reset mid-MEM_BUSY, then a late ready.
        mem_arb_req  = 1'b1;
        mem_arb_we   = 1'b0;
        mem_arb_addr = 32'h44;
        tick();
        chk("rstmid_granted", arb_ram_en, 1);
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        mem_arb_req   = 1'b0;
        ram_arb_ready = 1'b1;
        ram_arb_rdata = 32'h9999;
        tick();
        ram_arb_ready = 1'b0;
        starve_m      = 0;
        chk("rstmid_if_ack", arb_if_ack, 0);
        chk("rstmid_mem_ack", arb_mem_ack, 0);
        chk("rstmid_ram_en", arb_ram_en, 0);
        chk("rstmid_ram_we", arb_ram_we, 0);
        chk("rstmid_ram_addr", arb_ram_addr, 0);
        chk("rstmid_ram_wdata", arb_ram_wdata, 0);
        chk("rstmid_if_data", arb_if_data, 0);
        chk("rstmid_mem_data", arb_mem_data, 0);
        tick();
        chk("rstmid_idle_en", arb_ram_en, 0);
        chk("rstmid_idle_mem_ack", arb_mem_ack, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
